// File: rtl/rotate_seq_pkg.sv
// Shared definitions for the rotate sequencer: FSM state encoding and default widths.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//    DEF_DATA_W - default operand width
//    DEF_AMT_W  - default rotate-amount width
//    state_t    - sequencer FSM states (IDLE, SHIFT, DONE)
package rotate_seq_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_AMT_W  = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage : rotate_seq_pkg

// File: rtl/rotate_right.sv
// One-bit rotate-right of a W-bit word; bit 0 wraps into the MSB.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of din.
//
// Ports:
//    din  - word to rotate
//    dout - din rotated right by one position
module rotate_right #(
   parameter int W = 8
) (
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   assign dout = {din[0], din[W-1:1]};

endmodule : rotate_right

// File: rtl/rotate_sequencer.sv
// Multi-cycle rotator: accepts an operand and a step count, rotates one bit per cycle.
// Latency: done pulses amount+1 cycles after the accept cycle (1 cycle for amount 0).
// Backpressure: none; start is only honoured in IDLE, requests while busy are dropped.
//
// Optional feature: define ROTSEQ_LEFT_EN to let dir choose rotate-left (dir=1).
// Without it dir is ignored, every operation rotates right and no left path exists.
//
// Ports:
//    clk      - clock, all state changes on its rising edge
//    rst      - asynchronous active-high reset
//    start    - begin an operation (sampled in IDLE only)
//    data_in  - operand, captured on accept
//    amount   - number of single-bit rotate steps, captured on accept
//    dir      - 0 = right, 1 = left (only with ROTSEQ_LEFT_EN), captured on accept
//    busy     - high in SHIFT and DONE
//    done     - one-cycle completion pulse (DONE state)
//    data_out - working register, holds the result until the next accept
//    zero     - result is all zeros; valid from DONE onwards, held in IDLE
module rotate_sequencer
   import rotate_seq_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int AMT_W  = DEF_AMT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] data_in,
   input  logic [AMT_W-1:0]  amount,
   input  logic              dir,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] data_out,
   output logic              zero
);

   state_t            state;
   state_t            state_nxt;
   logic [AMT_W-1:0]  count;
   logic [DATA_W-1:0] work;
   logic [DATA_W-1:0] ror_dat;
   logic [DATA_W-1:0] step_dat;
   logic              zero_q;
   logic              accept;

   // ------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // FSM next-state and output decode
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            // busy stays low even in the accept cycle
            if (start) begin
               accept    = 1'b1;
               state_nxt = (amount != '0) ? SHIFT : DONE;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            // count holds the steps still to do including this one
            if (count == AMT_W'(1)) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Single-step rotate datapath
   // ------------------------------------------------------------------
   rotate_right #(
      .W (DATA_W)
   ) u_ror (
      .din  (work),
      .dout (ror_dat)
   );

`ifdef ROTSEQ_LEFT_EN
   logic              dir_q;
   logic [DATA_W-1:0] rol_dat;

   assign rol_dat  = {work[DATA_W-2:0], work[DATA_W-1]};
   assign step_dat = dir_q ? rol_dat : ror_dat;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dir_q <= 1'b0;
      end else if (accept) begin
         dir_q <= dir;
      end
   end
`else
   // Right-only build: dir is kept on the port for pin compatibility.
   logic unused_dir;

   assign unused_dir = dir;
   assign step_dat   = ror_dat;
`endif

   // ------------------------------------------------------------------
   // Working register, step counter and zero flag
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         work  <= '0;
         count <= '0;
      end else if (accept) begin
         work  <= data_in;
         count <= amount;
      end else if (state == SHIFT) begin
         work  <= step_dat;
         count <= count - AMT_W'(1);
      end
   end

   // The flag is captured while leaving DONE so that it survives into IDLE;
   // during DONE itself the live comparison is presented instead.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         zero_q <= 1'b0;
      end else if (state == DONE) begin
         zero_q <= (work == '0);
      end
   end

   assign data_out = work;
   assign zero     = (state == DONE) ? (work == '0) : zero_q;

endmodule : rotate_sequencer

// File: tb/tb_rotate_sequencer.sv
// Directed testbench for rotate_sequencer with hand-computed expectations.
// Latency: n/a.
// Backpressure: n/a.
module tb_rotate_sequencer;
   import rotate_seq_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic [2:0] amount = 3'd0;
   logic       dir = 1'b0;
   logic       busy;
   logic       done;
   logic [7:0] data_out;
   logic       zero;

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   rotate_sequencer #(
      .DATA_W (8),
      .AMT_W  (3)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .data_in  (data_in),
      .amount   (amount),
      .dir      (dir),
      .busy     (busy),
      .done     (done),
      .data_out (data_out),
      .zero     (zero)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; sample just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation from IDLE and wait for done; lat = cycles from accept.
   // Leaves the DUT back in IDLE on return.
   task automatic run_op(input logic [7:0] d, input logic [2:0] a, input logic r,
                         output int lat, output logic [7:0] res, output logic z);
      data_in = d;
      amount  = a;
      dir     = r;
      start   = 1'b1;
      step();
      start = 1'b0;
      lat   = 1;
      while (done !== 1'b1 && lat < 40) begin
         step();
         lat++;
      end
      res = data_out;
      z   = zero;
      step();
   endtask

   initial begin
      int         lat;
      logic [7:0] res;
      logic       z;
      logic [7:0] exp_left;

      // ---------------- reset state ----------------
      #1 rst = 1'b1;
      #2;
      check("rst_data_out", data_out, 8'h00);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_zero", zero, 1'b0);
      step();
      @(negedge clk);
      rst = 1'b0;
      step();

      // ---------------- 0x81 ror 1 ----------------
      data_in = 8'h81; amount = 3'd1; dir = 1'b0; start = 1'b1;
      step();                                   // cycle 1
      start = 1'b0;
      check("c29_c1_busy", busy, 1'b1);
      check("c29_c1_done", done, 1'b0);
      check("c29_c1_data", data_out, 8'h81);
      step();                                   // cycle 2
      check("c29_c2_done", done, 1'b1);
      check("c29_c2_busy", busy, 1'b1);
      check("c29_c2_data", data_out, 8'hC0);
      check("c29_c2_zero", zero, 1'b0);
      step();                                   // cycle 3, IDLE
      check("c29_c3_done", done, 1'b0);
      check("c29_c3_busy", busy, 1'b0);
      check("c29_c3_hold", data_out, 8'hC0);

      // ---------------- 0x01 ror 7 = rol 1 ----------------
      run_op(8'h01, 3'd7, 1'b0, lat, res, z);
      check("c30_latency", lat, 8);
      check("c30_data", res, 8'h02);

      // ---------------- 0x80 dir=1 ----------------
`ifdef ROTSEQ_LEFT_EN
      exp_left = 8'h01;
`else
      exp_left = 8'h40;
`endif
      run_op(8'h80, 3'd1, 1'b1, lat, res, z);
      check("c31_latency", lat, 2);
      check("c31_data", res, exp_left);

      // ---------------- more right rotates ----------------
      run_op(8'hA5, 3'd4, 1'b0, lat, res, z);
      check("ror4_latency", lat, 5);
      check("ror4_data", res, 8'h5A);
      run_op(8'h96, 3'd3, 1'b0, lat, res, z);
      check("ror3_data", res, 8'hD2);
      check("ror3_zero", z, 1'b0);

      // ---------------- zero operand, amount 0 ----------------
      data_in = 8'h00; amount = 3'd0; dir = 1'b0; start = 1'b1;
      step();                                   // cycle 1
      start = 1'b0;
      check("c32_done", done, 1'b1);
      check("c32_busy", busy, 1'b1);
      check("c32_data", data_out, 8'h00);
      check("c32_zero", zero, 1'b1);
      step();                                   // cycle 2
      check("c32_c2_busy", busy, 1'b0);
      check("c32_c2_done", done, 1'b0);
      check("c32_zero_hold", zero, 1'b1);

      // ---------------- ignored start, then reset mid-op ----------------
      data_in = 8'hF0; amount = 3'd5; dir = 1'b0; start = 1'b1;
      step();                                   // cycle 1
      start = 1'b0;
      step();                                   // cycle 2
      data_in = 8'h0F; start = 1'b1;
      step();                                   // cycle 3
      start = 1'b0;
      check("c33_busy", busy, 1'b1);
      check("c33_data", data_out, 8'h3C);
      rst = 1'b1;
      #1;
      check("c33_rst_data", data_out, 8'h00);
      check("c33_rst_busy", busy, 1'b0);
      check("c33_rst_done", done, 1'b0);
      check("c33_rst_zero", zero, 1'b0);
      step();
      step();
      check("c33_rst_held_done", done, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 7; k++) begin
         step();
         check("c33_no_done", done, 1'b0);
      end
      check("c33_idle_busy", busy, 1'b0);

      // ---------------- back-to-back with start held ----------------
      data_in = 8'h11; amount = 3'd2; dir = 1'b0; start = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         step();
         check("c34_done", done, (k == 3 || k == 7 || k == 11) ? 1'b1 : 1'b0);
         if (k == 2) data_in = 8'h03;
         if (k == 3) check("c34_c3_data", data_out, 8'h44);
         if (k == 4) check("c34_c4_busy", busy, 1'b0);
         if (k == 7) check("c34_c7_data", data_out, 8'hC0);
      end
      start = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "simulation did not complete");
   end

endmodule : tb_rotate_sequencer
